// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, parity-mode
// encodings and an elaboration-time parameter legality check.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // True when a receiver parameter set is supported
    function automatic bit rx_params_legal(
        input int unsigned data_width,
        input int unsigned oversample,
        input int unsigned parity_mode,
        input int unsigned stop_bits,
        input int unsigned prescale_width
    );
        return (data_width >= 5) && (data_width <= 9) &&
               ((oversample == 8) || (oversample == 16)) &&
               (parity_mode <= PARITY_ODD) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (prescale_width >= 1);
    endfunction

    // 2-of-3 vote used for noise-tolerant bit sampling
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every prescale+1 clocks.
// The divisor is captured while clear is high, so a running frame
// never sees a prescale change.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [PrescaleWidth-1:0] prescale,
    output logic                     tick
);

    logic [PrescaleWidth-1:0] cnt;
    logic [PrescaleWidth-1:0] limit;

    // Divider counter with registered tick output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            limit <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            limit <= prescale;
            tick  <= 1'b0;
        end else if (cnt == limit) begin
            cnt   <= '0;
            tick  <= 1'b1;
        end else begin
            cnt   <= cnt + PrescaleWidth'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a valid/ready output word and one-cycle
// error pulses. Optional build macro UART_RX_MAJORITY_EN selects 2-of-3
// majority sampling around mid-bit; timing is the same either way.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DataWidth     = 8,
    parameter int unsigned Oversample    = 16,
    parameter int unsigned ParityMode    = 0,
    parameter int unsigned StopBits      = 1,
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PrescaleWidth-1:0] prescale_i,
    input  logic                     rxd_i,
    output logic [DataWidth-1:0]     m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     frame_err_o,
    output logic                     parity_err_o,
    output logic                     overrun_o,
    output logic                     busy_o
);

    localparam int unsigned TickWidth   = $clog2(Oversample);
    localparam int unsigned BitCntWidth = 4;
    localparam logic [TickWidth-1:0]   TickMid    = TickWidth'(Oversample / 2);
    localparam logic [TickWidth-1:0]   TickDecide = TickWidth'(Oversample / 2 + 1);
    localparam logic [BitCntWidth-1:0] LastData   = BitCntWidth'(DataWidth - 1);
    localparam logic [BitCntWidth-1:0] LastStop   = BitCntWidth'(StopBits - 1);

    if (!rx_params_legal(DataWidth, Oversample, ParityMode, StopBits, PrescaleWidth)) begin : g_param_check
        $error("uart_rx_cfg: unsupported parameter combination");
    end

    // Synchronizer and edge detector
    logic       sync_meta;
    logic       line;
    logic [1:0] sync_fill;
    logic       line_prev;
    logic       start_edge;

    // Two-flop synchronizer; line_prev only trusts the line once the
    // pipeline holds real samples, so a line low out of reset is no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
            sync_fill <= 2'b00;
            line_prev <= 1'b0;
        end else begin
            sync_meta <= rxd_i;
            line      <= sync_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            line_prev <= line & sync_fill[1];
        end
    end

    assign start_edge = line_prev & ~line;

    // FSM and datapath registers
    rx_state_e              state, state_nxt;
    logic [TickWidth-1:0]   tick_cnt, tick_cnt_nxt;
    logic [BitCntWidth-1:0] bit_cnt, bit_cnt_nxt;
    logic [DataWidth-1:0]   shreg, shreg_nxt;
    logic                   par_err, par_err_nxt;
    logic                   stop_err, stop_err_nxt;
    logic [DataWidth-1:0]   m_data_nxt;
    logic                   m_valid_nxt;
    logic                   frame_err_nxt;
    logic                   parity_err_nxt;
    logic                   overrun_nxt;
    logic                   busy_nxt;

    logic tick;
    logic baud_clear;
    logic decide;
    logic bit_val;
    logic par_bad;
    logic stop_low;

    assign baud_clear = (state == ST_IDLE) || (state == ST_WAIT_IDLE);

    uart_baud_tick #(
        .PrescaleWidth(PrescaleWidth)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .clear    (baud_clear),
        .prescale (prescale_i),
        .tick     (tick)
    );

    // Each bit is resolved one tick after its mid-point in both builds
    assign decide = tick && (tick_cnt == TickDecide);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TickWidth-1:0] TickEarly = TickWidth'(Oversample / 2 - 1);
    logic samp_early;
    logic samp_mid;

    // Capture the two samples preceding the decision tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == TickEarly) samp_early <= line;
            if (tick_cnt == TickMid)   samp_mid   <= line;
        end
    end

    assign bit_val = majority3(samp_early, samp_mid, line);
`else
    logic samp_mid;

    // Capture the single mid-bit sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_mid <= 1'b1;
        end else if (tick && (tick_cnt == TickMid)) begin
            samp_mid <= line;
        end
    end

    assign bit_val = samp_mid;
`endif

    assign par_bad  = (ParityMode == PARITY_ODD) ? ~(^shreg ^ bit_val) : (^shreg ^ bit_val);
    assign stop_low = stop_err | ~bit_val;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
            m_data_o     <= '0;
            m_valid_o    <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            overrun_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= state_nxt;
            tick_cnt     <= tick_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            shreg        <= shreg_nxt;
            par_err      <= par_err_nxt;
            stop_err     <= stop_err_nxt;
            m_data_o     <= m_data_nxt;
            m_valid_o    <= m_valid_nxt;
            frame_err_o  <= frame_err_nxt;
            parity_err_o <= parity_err_nxt;
            overrun_o    <= overrun_nxt;
            busy_o       <= busy_nxt;
        end
    end

    // Next-state, bit assembly, error and output-word logic
    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick_cnt;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        par_err_nxt    = par_err;
        stop_err_nxt   = stop_err;
        m_data_nxt     = m_data_o;
        m_valid_nxt    = m_valid_o & ~m_ready_i;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        overrun_nxt    = 1'b0;

        if (tick) begin
            tick_cnt_nxt = tick_cnt + TickWidth'(1);
        end

        case (state)
            ST_IDLE: begin
                tick_cnt_nxt = '0;
                if (start_edge) begin
                    state_nxt    = ST_START;
                    bit_cnt_nxt  = '0;
                    par_err_nxt  = 1'b0;
                    stop_err_nxt = 1'b0;
                end
            end
            ST_START: begin
                if (decide) begin
                    state_nxt = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shreg_nxt = {bit_val, shreg[DataWidth-1:1]};
                    if (bit_cnt == LastData) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = (ParityMode == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BitCntWidth'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    par_err_nxt = par_bad;
                    state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (bit_cnt == LastStop) begin
                        frame_err_nxt  = stop_low;
                        parity_err_nxt = par_err;
                        if (stop_low) begin
                            state_nxt = ST_WAIT_IDLE;
                        end else begin
                            state_nxt = ST_IDLE;
                            if (!par_err) begin
                                if (!m_valid_o || m_ready_i) begin
                                    m_data_nxt  = shreg;
                                    m_valid_nxt = 1'b1;
                                end else begin
                                    overrun_nxt = 1'b1;
                                end
                            end
                        end
                    end else begin
                        bit_cnt_nxt  = bit_cnt + BitCntWidth'(1);
                        stop_err_nxt = stop_low;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (line) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule
